pwm_peripheral: RTL and testbench

Drives the 16 user outputs from the configuration registers written over SPI: per-bit output enable, per-bit PWM select and a shared 8-bit duty cycle. Sits directly downstream of the SPI register file and consumes its five register outputs unchanged. A prescaler and an 8-bit period counter generate one common PWM waveform, nominally about 3 kHz from a 10 MHz clock. Each enabled output is either held static high or follows that waveform.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 28 ++
 rtl/pwm_peripheral.sv | 77 +++++++
 tb/tb_pwm_peripheral.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths, constants and types for the PWM output peripheral.
// Imported by pwm_prescaler and pwm_peripheral.
package pwm_pkg;

    localparam int PWM_CNT_W        = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int NUM_OUT          = 16;
    localparam int PRESCALE_DEFAULT = 13;

    typedef logic [PWM_CNT_W-1:0] duty_t;
    typedef logic [NUM_OUT-1:0]   out_vec_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divider: pulses tick for one clk every PRESCALE cycles.
// Ports: clk, rst (sync, active high), tick (one-cycle strobe).
module pwm_prescaler #(
    parameter int PRESCALE = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] pre;

    // With PRESCALE = 1, LAST is 0 and tick stays high every cycle.
    assign tick = (pre == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 user outputs as static-high or a shared PWM waveform.
// Ports: clk, rst, en_reg_* / pwm_duty_cycle (SPI regs), out, period_start.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         en_reg_out_7_0,
    input  logic [7:0]         en_reg_out_15_8,
    input  logic [7:0]         en_reg_pwm_7_0,
    input  logic [7:0]         en_reg_pwm_15_8,
    input  logic [7:0]         pwm_duty_cycle,
    output logic [NUM_OUT-1:0] out,
    output logic               period_start
);

    logic                 tick;
    logic [PWM_CNT_W-1:0] cnt;
    duty_t                duty_q;
    logic                 wrap;
    logic                 wrap_q;
    logic                 pwm_raw;
    out_vec_t             en_out;
    out_vec_t             en_pwm;
    out_vec_t             out_nxt;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Last tick of a period: counter wraps and the duty is re-latched.
    assign wrap = tick & (cnt == {PWM_CNT_W{1'b1}});

    always_comb begin
        pwm_raw = 1'b0;
        out_nxt = '0;
        // Full scale is forced high so duty 255 has no low tick at cnt 255.
        if (duty_q == DUTY_FULL) begin
            pwm_raw = 1'b1;
        end else begin
            pwm_raw = (cnt < duty_q);
        end
        out_nxt = en_out & (~en_pwm | {NUM_OUT{pwm_raw}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            duty_q       <= '0;
            wrap_q       <= 1'b0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
            if (wrap) begin
                duty_q <= pwm_duty_cycle;
            end
            // wrap_q marks the first cycle with cnt = 0; one more stage
            // lines period_start up with the registered out.
            wrap_q       <= wrap;
            period_start <= wrap_q;
            out          <= out_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral with PRESCALE = 13.
// Expected out/period_start per cycle are queued; a monitor compares.
module tb_pwm_peripheral;

    localparam int TK  = 13;
    localparam int PER = 256 * TK;

    typedef struct {
        int          cyc;
        logic [15:0] o;
        logic        ps;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  en_reg_out_7_0  = '0;
    logic [7:0]  en_reg_out_15_8 = '0;
    logic [7:0]  en_reg_pwm_7_0  = '0;
    logic [7:0]  en_reg_pwm_15_8 = '0;
    logic [7:0]  pwm_duty_cycle  = '0;
    logic [15:0] out;
    logic        period_start;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pwm_peripheral #(
        .PRESCALE (TK)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || out !== e.o || period_start !== e.ps) begin
                errors++;
                $display("FAIL %s cyc %0d/%0d out %h want %h ps %b want %b",
                         e.nm, cyc, e.cyc, out, e.o, period_start, e.ps);
            end
        end
    end

    task automatic push1(input int c, input logic [15:0] o,
                         input logic ps, input string nm);
        exp_t e;
        e.cyc = c;
        e.o   = o;
        e.ps  = ps;
        e.nm  = nm;
        q.push_back(e);
    endtask

    // j counts cycles after the last reset edge; out(j) reflects the
    // counter state of cycle j-1. Period p >= 1 starts at j = p*PER+1.
    task automatic push_span(input int t0, input int jlo, input int jhi,
                             input logic [15:0] eo, input logic [15:0] ep,
                             input int d1, input int d2, input string nm);
        for (int j = jlo; j <= jhi; j++) begin
            int   p;
            int   k;
            int   d;
            logic pw;
            if (j == 0) begin
                push1(t0, 16'h0000, 1'b0, nm);
            end else begin
                p  = (j - 1) / PER;
                k  = (j - 1) % PER;
                d  = (p == 0) ? 0 : ((p == 1) ? d1 : d2);
                pw = (d == 255) ? 1'b1 : ((k / TK) < d);
                push1(t0 + j, eo & (~ep | {16{pw}}), (p > 0 && k == 0), nm);
            end
        end
    endtask

    task automatic start_test(input logic [15:0] eo, input logic [15:0] ep,
                              input logic [7:0] d, output int t0);
        int c0;
        c0  = cyc;
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) push1(c0 + i, 16'h0000, 1'b0, "reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
        pwm_duty_cycle = d;
        t0 = cyc;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() > 0 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout left %0d want 0", nm, q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int t1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'hFF;
        pwm_duty_cycle  = 8'hFF;
        start_test(16'hFFFF, 16'hFFFF, 8'd255, t0);
        push_span(t0, 0, 3 * PER + 1, 16'hFFFF, 16'hFFFF, 255, 255, "duty255");
        drain("duty255");

        start_test(16'hA5C3, 16'h0000, 8'd0, t0);
        push_span(t0, 0, 2 * PER + 1, 16'hA5C3, 16'h0000, 0, 0, "static");
        drain("static");

        start_test(16'hFFFF, 16'hFFFF, 8'd128, t0);
        push_span(t0, 0, 3 * PER + 1, 16'hFFFF, 16'hFFFF, 128, 128, "duty128");
        drain("duty128");

        start_test(16'hFFFF, 16'hFFFF, 8'd0, t0);
        push_span(t0, 0, 2 * PER + 1, 16'hFFFF, 16'hFFFF, 0, 0, "duty0");
        drain("duty0");

        start_test(16'hFFFF, 16'hFFFF, 8'd1, t0);
        push_span(t0, 0, 2 * PER + 1, 16'hFFFF, 16'hFFFF, 1, 1, "duty1");
        drain("duty1");

        start_test(16'hFFFF, 16'hFFFF, 8'd64, t0);
        push_span(t0, 0, 3 * PER + 1, 16'hFFFF, 16'hFFFF, 64, 192, "middc");
        repeat (PER + 100 * TK) @(posedge clk);
        #1;
        pwm_duty_cycle = 8'd192;
        drain("middc");

        start_test(16'h00FF, 16'hFF0F, 8'd64, t0);
        push_span(t0, 0, PER + 30 * TK, 16'h00FF, 16'hFF0F, 64, 64, "mixed");
        push1(t0 + PER + 30 * TK + 1, 16'h0000, 1'b0, "midrst");
        repeat (PER + 30 * TK) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t1 = cyc;
        push_span(t1, 1, 2 * PER + 1, 16'h00FF, 16'hFF0F, 64, 64, "restart");
        drain("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
